// File: rtl/muldiv_ctrl_if.sv
// Pipeline-side bundle for the EX-stage multiply/divide sequencer:
// issue operands, flush, MTHI/MTLO write path, and the stall/done/HI/LO results.
interface muldiv_ctrl_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        mthi_we;
   logic        mtlo_we;
   logic [31:0] mt_wdata;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, src_a, src_b, flush, mthi_we, mtlo_we, mt_wdata,
      input  stall, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, flush, mthi_we, mtlo_we, mt_wdata,
      output stall, done, hi, lo
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage: fixed-latency
// multiply, radix-2 restoring divide, and ownership of architectural HI/LO.
module muldiv_ctrl #(
   parameter int unsigned MUL_CYCLES = 2
) (
   input logic          clk,
   input logic          resetn,
   muldiv_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [4:0] MUL_CNT0 = 5'(MUL_CYCLES - 1);

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [32:0] dvs_q, dvs_d;
   logic [31:0] rhi_q, rhi_d;
   logic [31:0] rlo_q, rlo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        issue;
   logic        commit;
   logic        sgn_in;
   logic [32:0] a_sx, a_abs33;
   logic [32:0] b_sx, b_abs;
   logic        sgn_q;
   logic [63:0] a_ext, b_ext, prod;
   logic [32:0] rem_sh;
   logic [33:0] trial;
   logic        trial_ge;
   logic        q_neg, r_neg;
   logic        div_unused;

   assign issue  = (state_q == S_IDLE) && bus.start && !bus.flush;
   assign commit = (state_q == S_DONE) && !bus.flush;

   // Magnitudes are formed at 33 bits so |0x80000000| stays exact.
   assign sgn_in  = ~bus.op[0];
   assign a_sx    = {sgn_in & bus.src_a[31], bus.src_a};
   assign a_abs33 = a_sx[32] ? (33'd0 - a_sx) : a_sx;
   assign b_sx    = {sgn_in & bus.src_b[31], bus.src_b};
   assign b_abs   = b_sx[32] ? (33'd0 - b_sx) : b_sx;

   assign sgn_q = ~op_q[0];
   assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
   assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
   assign prod  = a_ext * b_ext;

   // 34-bit trial keeps the borrow distinct from a 33-bit partial remainder.
   assign rem_sh   = {rem_q, quo_q[31]};
   assign trial    = {1'b0, rem_sh} - {1'b0, dvs_q};
   assign trial_ge = ~trial[33];

   assign q_neg = sgn_q & (a_q[31] ^ b_q[31]);
   assign r_neg = sgn_q & a_q[31];

   assign div_unused = ^{trial[32], a_abs33[32]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      rhi_d   = rhi_q;
      rlo_d   = rlo_q;

      case (state_q)
         S_IDLE: begin
            if (issue) begin
               op_d = bus.op;
               a_d  = bus.src_a;
               b_d  = bus.src_b;
               if (bus.op[1]) begin
                  state_d = S_DIV;
                  cnt_d   = 5'd31;
                  quo_d   = a_abs33[31:0];
                  dvs_d   = b_abs;
                  rem_d   = '0;
               end else begin
                  state_d = S_MUL;
                  cnt_d   = MUL_CNT0;
               end
            end
         end
         S_MUL: begin
            rhi_d = prod[63:32];
            rlo_d = prod[31:0];
            if (cnt_q == '0) state_d = S_DONE;
            else             cnt_d   = cnt_q - 5'd1;
         end
         S_DIV: begin
            quo_d = {quo_q[30:0], trial_ge};
            rem_d = trial_ge ? trial[31:0] : rem_sh[31:0];
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - 5'd1;
         end
         S_FIX: begin
            if (b_q == '0) begin
               rlo_d = '1;
               rhi_d = a_q;
            end else begin
               rlo_d = q_neg ? (32'd0 - quo_q) : quo_q;
               rhi_d = r_neg ? (32'd0 - rem_q) : rem_q;
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (bus.flush) state_d = S_IDLE;
   end

   // The DONE commit is younger in program order than a WB-stage MTHI/MTLO.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (bus.mthi_we) hi_d = bus.mt_wdata;
      if (bus.mtlo_we) lo_d = bus.mt_wdata;
      if (commit) begin
         hi_d = rhi_q;
         lo_d = rlo_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         rhi_q   <= '0;
         rlo_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         rhi_q   <= rhi_d;
         rlo_q   <= rlo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.stall = ((state_q != S_IDLE) && (state_q != S_DONE)) || issue;
   assign bus.done  = commit;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, results, flush, MTHI/MTLO
// collision, back-to-back issue and asynchronous reset.
module tb_muldiv_ctrl;

   logic clk;
   logic resetn;
   int   total;
   int   bad;

   muldiv_ctrl_if bus();

   muldiv_ctrl #(.MUL_CYCLES(2)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called just after a rising edge; that cycle is the issue cycle (cycle 0).
   // Returns just after the edge that ends the DONE cycle, with start dropped.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int n_stall, output int done_at,
                         output logic [31:0] hi_at_done, output logic [31:0] lo_at_done);
      n_stall    = 0;
      done_at    = -1;
      hi_at_done = '0;
      lo_at_done = '0;
      bus.start  = 1'b1;
      bus.op     = o;
      bus.src_a  = a;
      bus.src_b  = b;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (bus.stall) n_stall++;
         if (bus.done) begin
            done_at    = c;
            hi_at_done = bus.hi;
            lo_at_done = bus.lo;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      bus.start    = 1'b0;
      bus.op       = 2'b00;
      bus.src_a    = '0;
      bus.src_b    = '0;
      bus.flush    = 1'b0;
      bus.mthi_we  = 1'b0;
      bus.mtlo_we  = 1'b0;
      bus.mt_wdata = '0;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
      total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 00000000", bus.hi); end
      total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 00000000", bus.lo); end
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mult();
      int ns, da;
      logic [31:0] h0, l0;
      run_op(2'b00, 32'hFFFFFFFE, 32'd3, ns, da, h0, l0);
      total++; if (ns !== 3) begin bad++; $display("FAIL mult_stall_cycles: got %0d want 3", ns); end
      total++; if (da !== 3) begin bad++; $display("FAIL mult_done_cycle: got %0d want 3", da); end
      total++; if (h0 !== 32'h0) begin bad++; $display("FAIL mult_hi_early: got %h want 00000000", h0); end
      total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi: got %h want FFFFFFFF", bus.hi); end
      total++; if (bus.lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo: got %h want FFFFFFFA", bus.lo); end
      run_op(2'b01, 32'hFFFFFFFE, 32'd3, ns, da, h0, l0);
      total++; if (da !== 3) begin bad++; $display("FAIL multu_done_cycle: got %0d want 3", da); end
      total++; if (bus.hi !== 32'h00000002) begin bad++; $display("FAIL multu_hi: got %h want 00000002", bus.hi); end
      total++; if (bus.lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL multu_lo: got %h want FFFFFFFA", bus.lo); end
   endtask

   task automatic test_div();
      int ns, da;
      logic [31:0] h0, l0;
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, ns, da, h0, l0);
      total++; if (ns !== 34) begin bad++; $display("FAIL div_stall_cycles: got %0d want 34", ns); end
      total++; if (da !== 34) begin bad++; $display("FAIL div_done_cycle: got %0d want 34", da); end
      total++; if (bus.lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo: got %h want FFFFFFFD", bus.lo); end
      total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi: got %h want FFFFFFFF", bus.hi); end
      run_op(2'b11, 32'd100, 32'd7, ns, da, h0, l0);
      total++; if (bus.lo !== 32'd14) begin bad++; $display("FAIL divu_lo: got %h want 0000000E", bus.lo); end
      total++; if (bus.hi !== 32'd2) begin bad++; $display("FAIL divu_hi: got %h want 00000002", bus.hi); end
   endtask

   task automatic test_div_edge();
      int ns, da;
      logic [31:0] h0, l0;
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, ns, da, h0, l0);
      total++; if (bus.lo !== 32'h80000000) begin bad++; $display("FAIL div_ovf_lo: got %h want 80000000", bus.lo); end
      total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL div_ovf_hi: got %h want 00000000", bus.hi); end
      run_op(2'b11, 32'd5, 32'd0, ns, da, h0, l0);
      total++; if (da !== 34) begin bad++; $display("FAIL div0_done_cycle: got %0d want 34", da); end
      total++; if (bus.lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL div0_lo: got %h want FFFFFFFF", bus.lo); end
      total++; if (bus.hi !== 32'd5) begin bad++; $display("FAIL div0_hi: got %h want 00000005", bus.hi); end
   endtask

   task automatic test_flush();
      int ns, da, n_done;
      logic [31:0] h0, l0;
      n_done    = 0;
      bus.start = 1'b1;
      bus.op    = 2'b10;
      bus.src_a = 32'd50;
      bus.src_b = 32'd3;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.done) n_done++;
         @(posedge clk); #1;
      end
      bus.flush = 1'b1;
      bus.start = 1'b0;
      @(negedge clk);
      if (bus.done) n_done++;
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL flush_stall_c10: got %b want 1", bus.stall); end
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.op    = 2'b00;
      @(negedge clk);
      if (bus.done) n_done++;
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_stall_c11: got %b want 0", bus.stall); end
      total++; if (n_done !== 0) begin bad++; $display("FAIL flush_no_done: got %0d pulses want 0", n_done); end
      total++; if (bus.hi !== 32'd5) begin bad++; $display("FAIL flush_hi_kept: got %h want 00000005", bus.hi); end
      total++; if (bus.lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL flush_lo_kept: got %h want FFFFFFFF", bus.lo); end
      @(posedge clk); #1;
      bus.flush = 1'b0;
      run_op(2'b00, 32'd3, 32'd4, ns, da, h0, l0);
      total++; if (da !== 3) begin bad++; $display("FAIL flush_restart_done: got %0d want 3", da); end
      total++; if (bus.lo !== 32'd12) begin bad++; $display("FAIL flush_restart_lo: got %h want 0000000C", bus.lo); end
      total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL flush_restart_hi: got %h want 00000000", bus.hi); end
   endtask

   task automatic test_mt();
      bus.start = 1'b1;
      bus.op    = 2'b01;
      bus.src_a = 32'hAAAA0000;
      bus.src_b = 32'h00010000;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
      end
      bus.mthi_we  = 1'b1;
      bus.mt_wdata = 32'h1234;
      @(negedge clk);
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL mt_done_c3: got %b want 1", bus.done); end
      @(posedge clk); #1;
      bus.start   = 1'b0;
      bus.mthi_we = 1'b0;
      total++; if (bus.hi !== 32'hAAAA) begin bad++; $display("FAIL mt_commit_wins_hi: got %h want 0000AAAA", bus.hi); end
      total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL mt_commit_lo: got %h want 00000000", bus.lo); end
      bus.mtlo_we  = 1'b1;
      bus.mt_wdata = 32'h55;
      @(posedge clk); #1;
      bus.mtlo_we = 1'b0;
      total++; if (bus.lo !== 32'h55) begin bad++; $display("FAIL mtlo_idle: got %h want 00000055", bus.lo); end
      total++; if (bus.hi !== 32'hAAAA) begin bad++; $display("FAIL mtlo_hi_kept: got %h want 0000AAAA", bus.hi); end
   endtask

   task automatic test_back_to_back();
      int ns, da;
      logic [31:0] h0, l0;
      run_op(2'b00, 32'd7, 32'd6, ns, da, h0, l0);
      total++; if (bus.lo !== 32'd42) begin bad++; $display("FAIL b2b_first_lo: got %h want 0000002A", bus.lo); end
      run_op(2'b00, 32'hFFFFFFFF, 32'd5, ns, da, h0, l0);
      total++; if (ns !== 3) begin bad++; $display("FAIL b2b_stall_cycles: got %0d want 3", ns); end
      total++; if (da !== 3) begin bad++; $display("FAIL b2b_done_cycle: got %0d want 3", da); end
      total++; if (l0 !== 32'd42) begin bad++; $display("FAIL b2b_lo_at_done: got %h want 0000002A", l0); end
      total++; if (bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_hi: got %h want FFFFFFFF", bus.hi); end
      total++; if (bus.lo !== 32'hFFFFFFFB) begin bad++; $display("FAIL b2b_lo: got %h want FFFFFFFB", bus.lo); end
   endtask

   task automatic test_reset_mid();
      int ns, da;
      logic [31:0] h0, l0;
      bus.start = 1'b1;
      bus.op    = 2'b10;
      bus.src_a = 32'd1000;
      bus.src_b = 32'd3;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      resetn    = 1'b0;
      #1;
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall: got %b want 0", bus.stall); end
      total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL rst_mid_hi: got %h want 00000000", bus.hi); end
      total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL rst_mid_lo: got %h want 00000000", bus.lo); end
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      total++; if (bus.stall !== 1'b0 || bus.done !== 1'b0) begin
         bad++; $display("FAIL rst_mid_idle: got stall=%b done=%b want 0 0", bus.stall, bus.done);
      end
      @(posedge clk); #1;
      run_op(2'b11, 32'd9, 32'd4, ns, da, h0, l0);
      total++; if (bus.lo !== 32'd2 || bus.hi !== 32'd1) begin
         bad++; $display("FAIL rst_mid_recover: got hi=%h lo=%h want 00000001 00000002", bus.hi, bus.lo);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_mult();
      test_div();
      test_div_edge();
      test_flush();
      test_mt();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
